prbs_checker: RTL
=================

# prbs_checker

Serial PRBS checker that sits directly downstream of the 4-bit PRBS generator and consumes its `rand` bit stream. It self-synchronises to the x^4+x^3+1 sequence (period 15, recurrence b[n] = b[n-4] ^ b[n-3]) and declares lock. While locked, it counts bit errors against a free-running local reference. Used for link and loopback bit-error-rate checks.

## Interface
Parameters:
- `ERR_CNT_W`, 16: width of saturating error counter.
- `LOCK_THRESH`, 8: consecutive correct predictions needed to declare lock (1..255).
- `LOSS_THRESH`, 4: consecutive mismatches while locked that drop lock (1..15).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `din` input 1: received PRBS bit.
- `din_vld` input 1: `din` is valid this cycle; the block ignores all other cycles.
- `err_clr` input 1: synchronous clear of the counters.
- `locked` output 1: sequence lock indicator.
- `err` output 1: one-cycle pulse per mismatched bit while locked.
- `err_cnt` output ERR_CNT_W: saturating count of errors seen while locked.

## Operation
- `hist[3:0]` shifts `{hist[2:0], bit}` on each valid bit. The predicted bit is `hist[3] ^ hist[2]`.
- `fill` counts the first 4 valid bits after entering SEARCH. No comparison takes place until `fill` = 4.
- SEARCH state:
  - `hist` shifts in `din`.
  - On a valid bit with `fill` = 4: if the bit matches and `hist` != 0, `match_cnt`++. Otherwise `match_cnt` = 0.
  - An all-zero history never counts, so an all-zero stream never locks.
  - When `match_cnt` reaches LOCK_THRESH, go to LOCKED and clear `bad_cnt`.
- LOCKED state:
  - `hist` shifts in the predicted bit, not `din`, so it acts as a free-running reference and a single bit error is counted exactly once.
  - On a mismatch: pulse `err`, increment `err_cnt` (saturating at all-ones), `bad_cnt`++.
  - On a match: `bad_cnt` = 0.
  - When `bad_cnt` reaches LOSS_THRESH, go to SEARCH and clear `match_cnt`, `fill`, and `hist`. The mismatch that triggers the loss is still counted and pulsed.
- `err_clr` clears `err_cnt`. If an error occurs in the same cycle, `err_cnt` becomes 1. `err_clr` does not affect lock state.
- Cycles with `din_vld` = 0 leave all state unchanged. `err` is 0 in those cycles.

## Timing
- Reset values: `locked` = 0, `err` = 0, `err_cnt` = 0. Internally: state = SEARCH, `hist` = 0, `fill` = 0, `match_cnt` = 0, `bad_cnt` = 0.
- Every output is registered. The response to the bit sampled at edge k is visible after edge k.
- Lock latency on a clean stream is 4 + LOCK_THRESH valid bits. `locked` rises in the cycle after the final matching bit.
- `err` and the `err_cnt` increment appear together, one cycle after the erroneous bit.
- `locked` falls one cycle after the LOSS_THRESH-th consecutive mismatch.
- `reset` asserted mid-lock returns every output to its reset value on the next edge. Reset takes priority over `err_clr` and `din_vld`.

## Configuration
- `PRBS_CHK_BIT_CNT_EN` defined: adds output `bit_cnt` [31:0], a saturating count of valid bits received while locked. It is cleared by `reset` and `err_clr`; if a locked valid bit arrives in the same cycle as `err_clr`, it becomes 1. BER = `err_cnt` / `bit_cnt`.
- `PRBS_CHK_BIT_CNT_EN` undefined: no `bit_cnt` port and no associated logic.

## Structure
- Package `prbs_pkg` holds:
  - `LFSR_W` = 4.
  - Tap constants for bit positions 3 and 2.
  - Enum `prbs_chk_state_t` {SEARCH, LOCKED}.
- Sub-module `prbs_sat_cnt`: a parameterised width saturating counter with inc/clr, where clr has priority but a simultaneous inc yields 1. It is instantiated for `err_cnt` and, when enabled, for `bit_cnt`.

## Test plan
- Generator stream seeded 1111 with `din_vld` held at 1: `locked` rises after bit 12, then stays high for 100 bits with `err_cnt` = 0.
- Flip one bit while locked: a single `err` pulse, `err_cnt` = 1, `locked` stays 1.
- All-zero `din` for 50 bits: `locked` stays 0 and `err_cnt` stays 0.
- Invert 4 consecutive bits while locked with defaults: `locked` falls one cycle after the 4th bit, `err_cnt` = 4. Re-lock occurs 12 valid bits after a clean stream resumes.
- With ERR_CNT_W = 4, inject 20 isolated errors: `err_cnt` saturates at 15. Then `err_clr` together with an error gives `err_cnt` = 1.
- Assert `reset` while locked, with `din_vld` toggling: all outputs are 0 on the next cycle. Lock is regained with the normal 4 + LOCK_THRESH latency.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the x^4+x^3+1 PRBS checker: LFSR width, tap
// positions used for prediction, the checker state type and the predictor.
package prbs_pkg;

  localparam int LFSR_W = 4;
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 2;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_chk_state_t;

  // Next bit of the sequence given the last four bits (oldest in the MSB).
  function automatic logic prbs_predict(input logic [LFSR_W-1:0] h);
    return h[TAP_HI] ^ h[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear wins over increment,
// but a simultaneous increment makes the result 1 so no event is lost.
module prbs_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear (optionally seeded with 1), else increment until all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Serial checker for the x^4+x^3+1 PRBS stream. Self-synchronises on the
// received bits, then runs a free-running local reference and counts bit
// errors while locked. Optional macro PRBS_CHK_BIT_CNT_EN adds a bit_cnt
// output counting valid bits received while locked (for BER computation).
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int ERR_CNT_W   = 16,
  parameter int LOCK_THRESH = 8,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  input  logic                 din_vld,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef PRBS_CHK_BIT_CNT_EN
  ,
  output logic [31:0]          bit_cnt
`endif
);

  localparam logic [7:0] LOCK_THRESH_C = 8'(LOCK_THRESH);
  localparam logic [3:0] LOSS_THRESH_C = 4'(LOSS_THRESH);
  localparam logic [2:0] FILL_FULL     = 3'(LFSR_W);

  prbs_chk_state_t   state_q, state_d;
  logic [LFSR_W-1:0] hist_q, hist_d;
  logic [2:0]        fill_q, fill_d;
  logic [7:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        bad_cnt_q, bad_cnt_d;
  logic              err_q, err_d;
  logic              err_inc;
  logic              pred;
  logic              mismatch;

  assign pred     = prbs_predict(hist_q);
  assign mismatch = din ^ pred;

  // Next-state: history fill and match counting while searching; reference
  // tracking, error flagging and loss detection while locked.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_d       = 1'b0;
    err_inc     = 1'b0;
    if (din_vld) begin
      case (state_q)
        SEARCH: begin
          hist_d = {hist_q[LFSR_W-2:0], din};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 3'd1;
          end else if (!mismatch && (hist_q != '0)) begin
            match_cnt_d = match_cnt_q + 8'd1;
            if (match_cnt_d == LOCK_THRESH_C) begin
              state_d   = LOCKED;
              bad_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          hist_d = {hist_q[LFSR_W-2:0], pred};
          if (mismatch) begin
            err_d     = 1'b1;
            err_inc   = 1'b1;
            bad_cnt_d = bad_cnt_q + 4'd1;
            if (bad_cnt_d == LOSS_THRESH_C) begin
              state_d     = SEARCH;
              match_cnt_d = '0;
              fill_d      = '0;
              hist_d      = '0;
              bad_cnt_d   = '0;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      match_cnt_q <= '0;
      bad_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_q       <= err_d;
    end
  end

  assign locked = (state_q == LOCKED);
  assign err    = err_q;

  prbs_sat_cnt #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (err_clr),
    .cnt   (err_cnt)
  );

`ifdef PRBS_CHK_BIT_CNT_EN
  logic bit_inc;

  assign bit_inc = din_vld && (state_q == LOCKED);

  prbs_sat_cnt #(
    .W (32)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bit_inc),
    .clr   (err_clr),
    .cnt   (bit_cnt)
  );
`endif

endmodule
